// File: rtl/led_share_arbiter_pkg.sv
// Shared types and helpers for the LED bank arbiter: FSM states, the
// all-off LED constant and the round-robin winner picker.
package led_arb_pkg;

  typedef enum logic [1:0] {IDLE, GRANT, GAP} arb_state_t;

  // LEDs are active-low, so all ones means the bank is dark.
  localparam logic [31:0] IDLE_LED_ALL_OFF = '1;

  localparam int MAX_REQ = 8;

  // Returns the one-hot winner: first set bit searching ptr+1, ptr+2, ... mod n.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                 input logic [2:0] ptr,
                                                 input int n);
    logic [MAX_REQ-1:0] win;
    logic               found;
    logic [2:0]         idx;
    win   = '0;
    found = 1'b0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      idx = 3'((int'(ptr) + k) % n);
      if (k <= n && !found && req[idx]) begin
        win[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/led_share_arbiter_if.sv
// Request/grant/LED bundle between the pattern sources and the arbiter.
interface led_share_arbiter_if #(
  parameter int N = 3,
  parameter int W = 6
);
  logic [N-1:0]   req;
  logic [N*W-1:0] led_val;
  logic [N-1:0]   gnt;
  logic [W-1:0]   led;
  logic           busy;
  logic           revoked;

  modport master (output req, led_val, input gnt, led, busy, revoked);
  modport slave  (input req, led_val, output gnt, led, busy, revoked);
endinterface

// File: rtl/led_share_arbiter_hold_timer.sv
// Hold budget timer: a DIV-cycle tick prescaler feeding a tick counter that
// flags expiry on the last cycle of the MAX_HOLD-th tick.
module led_hold_timer #(
  parameter int DIV      = 27_000_000,
  parameter int MAX_HOLD = 4
) (
  input  logic sys_clk,
  input  logic sys_reset_n,
  input  logic start,
  input  logic run,
  output logic expire
);
  localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int HW = $clog2(MAX_HOLD + 1);

  logic [TW-1:0] tick_cnt;
  logic [HW-1:0] hold_cnt;
  logic          tick_last;

  assign tick_last = (tick_cnt == TW'(DIV - 1));

  always_ff @(posedge sys_clk) begin
    if (!sys_reset_n || start) begin
      tick_cnt <= '0;
      hold_cnt <= '0;
    end else if (run) begin
      if (tick_last) begin
        tick_cnt <= '0;
        if (hold_cnt != HW'(MAX_HOLD)) hold_cnt <= hold_cnt + 1'b1;
      end else begin
        tick_cnt <= tick_cnt + 1'b1;
      end
    end
  end

  // Asserted on the edge where the hold count would reach MAX_HOLD.
  assign expire = run && tick_last && (hold_cnt == HW'(MAX_HOLD - 1));

endmodule

// File: rtl/led_share_arbiter.sv
// Round-robin owner of the LED bank: one requester at a time drives the LEDs,
// with a one-cycle dark gap between grants and a forced revoke on timeout.
module led_share_arbiter
  import led_arb_pkg::*;
#(
  parameter int           N        = 3,
  parameter int           W        = 6,
  parameter int           DIV      = 27_000_000,
  parameter int           MAX_HOLD = 4,
  parameter logic [W-1:0] IDLE_LED = W'(IDLE_LED_ALL_OFF)
) (
  input  logic               sys_clk,
  input  logic               sys_reset_n,
  led_share_arbiter_if.slave bus
);
  localparam int PW = $clog2(N);

  arb_state_t    state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d, gnt_pick;
  logic [W-1:0]  led_q, led_d, owner_led;
  logic          busy_q, busy_d, revoked_q, revoked_d;
  logic [PW-1:0] rr_ptr_q, rr_ptr_d, win_idx;
  logic          start, run, expire, owner_req;

  assign gnt_pick  = N'(rr_pick(MAX_REQ'(bus.req), 3'(rr_ptr_q), N));
  assign owner_req = |(bus.req & gnt_q);
  assign run       = (state_q == GRANT);

  // While granted, rr_ptr_q doubles as the owner index.
  always_comb begin
    owner_led = IDLE_LED;
    win_idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (rr_ptr_q == PW'(i)) owner_led = bus.led_val[i*W +: W];
      if (gnt_pick[i])        win_idx   = PW'(i);
    end
  end

  led_hold_timer #(.DIV(DIV), .MAX_HOLD(MAX_HOLD)) u_timer (
    .sys_clk     (sys_clk),
    .sys_reset_n (sys_reset_n),
    .start       (start),
    .run         (run),
    .expire      (expire)
  );

  always_comb begin
    state_d   = state_q;
    gnt_d     = '0;
    led_d     = IDLE_LED;
    busy_d    = 1'b0;
    revoked_d = 1'b0;
    rr_ptr_d  = rr_ptr_q;
    start     = 1'b0;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          state_d  = GRANT;
          gnt_d    = gnt_pick;
          busy_d   = 1'b1;
          rr_ptr_d = win_idx;
          start    = 1'b1;
        end
      end
      GRANT: begin
        // A release on the expiry edge wins, so no revoke pulse then.
        if (!owner_req) begin
          state_d = GAP;
        end else if (expire) begin
          state_d   = GAP;
          revoked_d = 1'b1;
        end else begin
          gnt_d  = gnt_q;
          busy_d = 1'b1;
          led_d  = owner_led;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_reset_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      led_q     <= IDLE_LED;
      busy_q    <= 1'b0;
      revoked_q <= 1'b0;
      rr_ptr_q  <= PW'(N - 1);
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      led_q     <= led_d;
      busy_q    <= busy_d;
      revoked_q <= revoked_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.led     = led_q;
  assign bus.busy    = busy_q;
  assign bus.revoked = revoked_q;

endmodule

// File: tb/tb_led_share_arbiter.sv
// Scoreboarded bench for led_share_arbiter: directed request sequences push
// expected grants; a negedge monitor closes each observed grant against them.
module tb_led_share_arbiter;

  typedef struct {
    logic [2:0] gnt;
    int         len;
    logic       revoked;
    logic [5:0] led;
  } exp_t;

  logic sys_clk;
  logic sys_reset_n;
  int   checks;
  int   errors;
  logic mon_en;

  exp_t       exp_q[$];
  logic [2:0] cur_gnt;
  int         run_len;
  logic [5:0] led_mid;

  led_share_arbiter_if #(.N(3), .W(6)) bus ();

  led_share_arbiter #(
    .N(3), .W(6), .DIV(5), .MAX_HOLD(4), .IDLE_LED(6'h3F)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_reset_n (sys_reset_n),
    .bus         (bus)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic cmp(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
    end
  endtask

  task automatic waitClk(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [2:0] r, input int n);
    bus.req = r;
    waitClk(n);
  endtask

  task automatic expectGrant(input logic [2:0] g, input int len, input logic rv, input logic [5:0] l);
    exp_t e;
    e.gnt = g; e.len = len; e.revoked = rv; e.led = l;
    exp_q.push_back(e);
  endtask

  task automatic checkOutput(input string name, input logic [2:0] g, input logic [5:0] l,
                             input logic b, input logic rv);
    cmp({name, ".gnt"},     int'(bus.gnt),     int'(g));
    cmp({name, ".led"},     int'(bus.led),     int'(l));
    cmp({name, ".busy"},    int'(bus.busy),    int'(b));
    cmp({name, ".revoked"}, int'(bus.revoked), int'(rv));
  endtask

  task automatic closeGrant();
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL unexpected_grant actual=%0h len=%0d required=none", cur_gnt, run_len);
    end else begin
      e = exp_q.pop_front();
      cmp("grant_owner", int'(cur_gnt),     int'(e.gnt));
      cmp("grant_len",   run_len,           e.len);
      cmp("grant_led",   int'(led_mid),     int'(e.led));
      cmp("gap_revoked", int'(bus.revoked), int'(e.revoked));
      cmp("gap_led",     int'(bus.led),     32'h3F);
    end
    cur_gnt = 3'b000;
  endtask

  // Monitor: tracks grant runs and checks one-hot ownership every cycle.
  always @(negedge sys_clk) begin
    if (mon_en) begin
      checks++;
      if (!$onehot0(bus.gnt)) begin
        errors++;
        $display("[TB] FAIL gnt_onehot actual=%b required=one-hot-or-zero", bus.gnt);
      end
      if (cur_gnt != 3'b000 && bus.gnt != cur_gnt) closeGrant();
      if (bus.gnt != 3'b000 && bus.gnt != cur_gnt) begin
        cur_gnt = bus.gnt;
        run_len = 1;
        led_mid = 6'h00;
      end else if (bus.gnt != 3'b000) begin
        run_len++;
        if (run_len == 2) led_mid = bus.led;
      end
    end
  end

  initial begin
    checks      = 0;
    errors      = 0;
    mon_en      = 1'b0;
    cur_gnt     = 3'b000;
    run_len     = 0;
    led_mid     = 6'h00;
    sys_reset_n = 1'b0;
    bus.req     = 3'b111;
    bus.led_val = {6'h30, 6'h0C, 6'h03};

    // Reset with all requests pending, then requester 0 wins first.
    waitClk(1);
    mon_en = 1'b1;
    waitClk(2);
    checkOutput("reset", 3'b000, 6'h3F, 1'b0, 1'b0);
    sys_reset_n = 1'b1;
    expectGrant(3'b001, 2, 1'b0, 6'h03);
    waitClk(1);
    checkOutput("first_grant", 3'b001, 6'h3F, 1'b1, 1'b0);
    waitClk(1);
    checkOutput("first_led", 3'b001, 6'h03, 1'b1, 1'b0);
    applyStimulus(3'b000, 1);
    checkOutput("first_release", 3'b000, 6'h3F, 1'b0, 1'b0);
    waitClk(2);

    // Voluntary release after 7 granted cycles.
    expectGrant(3'b010, 7, 1'b0, 6'h0C);
    applyStimulus(3'b010, 7);
    checkOutput("hold7", 3'b010, 6'h0C, 1'b1, 1'b0);
    applyStimulus(3'b000, 1);
    checkOutput("release_gap", 3'b000, 6'h3F, 1'b0, 1'b0);
    waitClk(1);
    checkOutput("release_idle", 3'b000, 6'h3F, 1'b0, 1'b0);
    waitClk(1);

    // Timeout after 20 cycles, then re-grant to the sole requester.
    expectGrant(3'b100, 20, 1'b1, 6'h30);
    expectGrant(3'b100, 2, 1'b0, 6'h30);
    applyStimulus(3'b100, 20);
    checkOutput("last_hold", 3'b100, 6'h30, 1'b1, 1'b0);
    waitClk(1);
    checkOutput("timeout_gap", 3'b000, 6'h3F, 1'b0, 1'b1);
    waitClk(1);
    checkOutput("timeout_idle", 3'b000, 6'h3F, 1'b0, 1'b0);
    waitClk(1);
    checkOutput("regrant", 3'b100, 6'h3F, 1'b1, 1'b0);
    applyStimulus(3'b100, 1);
    applyStimulus(3'b000, 3);

    // Round-robin with all requesting: 0,1,2,0, each timing out.
    expectGrant(3'b001, 20, 1'b1, 6'h03);
    expectGrant(3'b010, 20, 1'b1, 6'h0C);
    expectGrant(3'b100, 20, 1'b1, 6'h30);
    expectGrant(3'b001, 20, 1'b1, 6'h03);
    applyStimulus(3'b111, 87);
    checkOutput("rr_last_gap", 3'b000, 6'h3F, 1'b0, 1'b1);
    applyStimulus(3'b000, 3);

    // Release on the same edge as expiry counts as a release.
    expectGrant(3'b001, 20, 1'b0, 6'h03);
    applyStimulus(3'b001, 20);
    applyStimulus(3'b000, 1);
    checkOutput("simul_release", 3'b000, 6'h3F, 1'b0, 1'b0);
    waitClk(2);

    // Reset in cycle 10 of a grant; requester 0 wins first afterwards.
    expectGrant(3'b010, 10, 1'b0, 6'h0C);
    expectGrant(3'b001, 2, 1'b0, 6'h03);
    applyStimulus(3'b010, 10);
    sys_reset_n = 1'b0;
    waitClk(1);
    checkOutput("reset_mid", 3'b000, 6'h3F, 1'b0, 1'b0);
    sys_reset_n = 1'b1;
    applyStimulus(3'b011, 1);
    checkOutput("post_reset_winner", 3'b001, 6'h3F, 1'b1, 1'b0);
    applyStimulus(3'b011, 1);
    applyStimulus(3'b000, 3);

    cmp("pending_expectations", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_share_arbiter.md
Name: led_share_arbiter

Overview:
- Round-robin arbiter that shares the board LED bank (Tang Nano 9k, 6 active-low LEDs) between N requesters, such as a blinky, a status indicator or a debug pattern source.
- Each requester asks for ownership with a level req and gets a one-hot grant.
- The owner's pattern drives the LEDs until it releases or its hold budget expires.
- Sits between the pattern generators and the top-level led pins.

Parameters:
- N, 3, number of requesters (2..8).
- W, 6, LED bank width.
- DIV, 27_000_000, sys_clk cycles per hold tick (the bench uses 5).
- MAX_HOLD, 4, maximum ticks a grant is held before forced revoke (>=1).
- IDLE_LED, {W{1'b1}}, LED value when nobody owns the bank (all off, active-low).

Ports:
- sys_clk  in  1  system clock.
- sys_reset_n  in  1  synchronous, active-low reset.
- req  in  N  level request per requester; bit i = requester i.
- led_val  in  N*W  pattern per requester; slice [i*W +: W] belongs to requester i.
- gnt  out  N  one-hot grant, registered.
- led  out  W  LED bank drive, registered.
- busy  out  1  high while in GRANT.
- revoked  out  1  one-cycle pulse when a grant ends by timeout.

Behaviour:
- Single clock. Reset is synchronous and active-low: sampled on the sys_clk rising edge while sys_reset_n=0.
- Reset values: gnt=0, led=IDLE_LED, busy=0, revoked=0, state=IDLE, rr_ptr=N-1 (so requester 0 wins first), tick counter=0, hold counter=0.
- States:
  - IDLE: if req!=0, pick a winner and go to GRANT. Otherwise stay in IDLE with led=IDLE_LED.
  - GRANT: gnt holds the winner's one-hot bit, busy=1, led=led_val slice of the owner, updated every cycle (one-cycle registered latency from led_val).
  - GAP: exactly one cycle. gnt=0, busy=0, led=IDLE_LED. Always returns to IDLE.
- Winner selection: the first set req bit searching rr_ptr+1, rr_ptr+2, ... modulo N. On entering GRANT, rr_ptr is set to the winner.
- Grant latency: req seen in IDLE at edge k gives gnt and busy high after edge k. led shows that owner's pattern from edge k+1.
- Hold timing:
  - The tick counter runs 0..DIV-1 and restarts at 0 on every GRANT entry.
  - When it reaches DIV-1, the hold counter increments.
  - When the hold counter reaches MAX_HOLD, the grant is revoked. gnt is high for exactly MAX_HOLD*DIV cycles.
- Release: if req[owner]=0 in GRANT, the next edge goes to GAP. gnt drops after that edge, and revoked stays 0.
- Timeout: revoked pulses high for the GAP cycle. The revoked requester is still eligible, but round-robin serves every other pending requester first.
- Simultaneous release and timeout on the same edge: treat it as a release, so revoked=0.
- Requests that arrive or toggle for non-owners during GRANT or GAP have no effect until IDLE.
- Glitch-free ownership: gnt is never multi-hot, and a GAP cycle always separates two grants (including back-to-back grants to the same requester).
- Reset mid-grant: everything returns to reset values on that edge. The LEDs show IDLE_LED after the edge.
- Width rules:
  - tick counter = $clog2(DIV) bits.
  - hold counter = $clog2(MAX_HOLD+1) bits.
  - rr_ptr = $clog2(N) bits, with explicit wrap at N-1 (N need not be a power of two).

Decomposition:
- Package led_arb_pkg holds:
  - the state enum arb_state_t {IDLE, GRANT, GAP};
  - the default IDLE_LED constant;
  - the function rr_pick(req, ptr) that returns the one-hot winner.
- Sub-module led_hold_timer (sys_clk, sys_reset_n, start, tick/expire) owns the tick and hold counters. Parameters: DIV, MAX_HOLD.

Test Plan (N=3, W=6, DIV=5, MAX_HOLD=4, led_val={6'h30,6'h0C,6'h03}):
1. Reset: hold sys_reset_n=0 for 3 clks with req=3'b111 -> gnt=0, led=6'h3F, busy=0. On release of reset, the next edge gives gnt=3'b001, and led=6'h03 one cycle later.
2. Voluntary release: requester 1 only, drop req[1] after 7 granted cycles -> gnt=0 on the next edge. One GAP cycle with led=6'h3F, then IDLE. revoked stays 0.
3. Timeout: requester 2 holds req high -> gnt=3'b100 for exactly 20 cycles, then a 1-cycle revoked pulse. It is re-granted after GAP+IDLE, since it is the only requester.
4. Round-robin fairness: req=3'b111 held constantly -> the grant order is 0,1,2,0. Each grant lasts 20 cycles with a single GAP between grants, and gnt is never multi-hot (assert $onehot0 every cycle).
5. Simultaneous release at the expire edge: drop req[0] on the cycle the hold counter reaches 4 -> revoked=0 and the GAP occurs.
6. Reset mid-grant: assert sys_reset_n=0 during cycle 10 of a grant -> the next edge gives gnt=0, led=6'h3F, revoked=0. After reset the first winner is requester 0 again.
